vga_scan_reader: RTL and testbench

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

---
 rtl/vga_scan_pkg.sv | 22 ++
 rtl/vga_scan_delay.sv | 26 ++
 rtl/vga_scan_reader.sv | 142 ++++++++++++++
 tb/tb_vga_scan_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_pkg.sv
// rtl/vga_scan_pkg.sv - shared sync-polarity constants and timing helpers for the VGA scan reader
package vga_scan_pkg;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Counters are kept at least 5 bits wide so the test pattern can always tap bit 4.
  function automatic int cnt_width(input int total);
    int w;
    w = $clog2(total);
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/vga_scan_delay.sv
// rtl/vga_scan_delay.sv - N-stage register with a per-bit asynchronous reset value
module vga_scan_delay #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             mem_rd_clk,
  input  logic             mem_rd_rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [STAGES];

  always_ff @(posedge mem_rd_clk or negedge mem_rd_rst_n) begin
    if (!mem_rd_rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[STAGES-1];

endmodule

// File: rtl/vga_scan_reader.sv
// rtl/vga_scan_reader.sv - VGA raster scan that streams a frame buffer to pixel outputs
// Defining VGA_SCAN_PATTERN_EN adds the pat_en checkerboard test-pattern input.
module vga_scan_reader
  import vga_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int FB_DEPTH   = 512,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic                  mem_rd_clk,
  input  logic                  mem_rd_rst_n,
  input  logic                  scan_en,
`ifdef VGA_SCAN_PATTERN_EN
  input  logic                  pat_en,
`endif
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW    = cnt_width(H_TOT);
  localparam int VW    = cnt_width(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SBEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SEND  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SBEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SEND  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FB_DEPTH - 1);

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  active, frame_end, pat_on;
  logic                  de_raw, hs_raw, vs_raw, fs_raw;
  logic [3:0]            dly_q;
  logic                  de_d1;
  logic [DATA_WIDTH-1:0] pix_next;

`ifdef VGA_SCAN_PATTERN_EN
  assign pat_on = pat_en;
`else
  assign pat_on = 1'b0;
`endif

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Idle counters sit inside the active region, so reset must gate the strobe directly.
  assign mem_rd_en = mem_rd_rst_n && scan_en && active && !pat_on;
  assign mem_raddr = addr_q;

  always_ff @(posedge mem_rd_clk or negedge mem_rd_rst_n) begin
    if (!mem_rd_rst_n) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      addr_q <= '0;
    end else if (!scan_en) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      addr_q <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (frame_end)
        addr_q <= '0;
      else if (mem_rd_en)
        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end
  end

  assign de_raw = scan_en && active;
  assign hs_raw = (h_cnt >= H_SBEG && h_cnt < H_SEND) ? SYNC_POL : !SYNC_POL;
  assign vs_raw = (v_cnt >= V_SBEG && v_cnt < V_SEND) ? SYNC_POL : !SYNC_POL;
  assign fs_raw = scan_en && (h_cnt == '0) && (v_cnt == '0);

  vga_scan_delay #(
    .WIDTH   (4),
    .STAGES  (2),
    .RST_VAL ({1'b0, !SYNC_POL, !SYNC_POL, 1'b0})
  ) u_dly (
    .mem_rd_clk   (mem_rd_clk),
    .mem_rd_rst_n (mem_rd_rst_n),
    .din          ({fs_raw, vs_raw, hs_raw, de_raw}),
    .dout         (dly_q)
  );

  assign {frame_start, vsync, hsync, pix_de} = dly_q;

`ifdef VGA_SCAN_PATTERN_EN
  logic pat_d1, pat_bit_d1;

  always_ff @(posedge mem_rd_clk or negedge mem_rd_rst_n) begin
    if (!mem_rd_rst_n) begin
      pat_d1     <= 1'b0;
      pat_bit_d1 <= 1'b0;
    end else begin
      pat_d1     <= pat_on;
      pat_bit_d1 <= h_cnt[4] ^ v_cnt[4];
    end
  end

  assign pix_next = !de_d1 ? '0 : (pat_d1 ? {DATA_WIDTH{pat_bit_d1}} : mem_rdata);
`else
  assign pix_next = de_d1 ? mem_rdata : '0;
`endif

  // de_d1 lines up with mem_rdata, which returns one clock after the read strobe.
  always_ff @(posedge mem_rd_clk or negedge mem_rd_rst_n) begin
    if (!mem_rd_rst_n) begin
      de_d1    <= 1'b0;
      pix_data <= '0;
    end else begin
      de_d1    <= de_raw;
      pix_data <= pix_next;
    end
  end

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb/tb_vga_scan_reader.sv - self-checking bench for vga_scan_reader
module tb_vga_scan_reader;

  localparam int DW = 8;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, scan_en;
`ifdef VGA_SCAN_PATTERN_EN
  logic pat_en;
`endif
  logic [AW-1:0] raddr_a, raddr_b;
  logic          rd_a, rd_b;
  logic [DW-1:0] rdata_a, rdata_b, pix_a, pix_b;
  logic          de_a, de_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
  logic [DW-1:0] fb [12];

  vga_scan_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_DEPTH(12),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_a (
    .mem_rd_clk(clk), .mem_rd_rst_n(rst_n), .scan_en(scan_en),
`ifdef VGA_SCAN_PATTERN_EN
    .pat_en(pat_en),
`endif
    .mem_raddr(raddr_a), .mem_rd_en(rd_a), .mem_rdata(rdata_a),
    .pix_data(pix_a), .pix_de(de_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  vga_scan_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_DEPTH(10),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .mem_rd_clk(clk), .mem_rd_rst_n(rst_n), .scan_en(scan_en),
`ifdef VGA_SCAN_PATTERN_EN
    .pat_en(pat_en),
`endif
    .mem_raddr(raddr_b), .mem_rd_en(rd_b), .mem_rdata(rdata_b),
    .pix_data(pix_b), .pix_de(de_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  always @(posedge clk) begin
    if (rd_a) rdata_a <= fb[raddr_a];
    if (rd_b) rdata_b <= fb[raddr_b];
  end

  typedef struct {
    logic          de, hs, vs, fs;
    logic [DW-1:0] pix_a, pix_b;
  } exp_t;

  typedef struct {
    int   k;
    logic rd;
    int   a12;
    int   a10;
  } vec_t;

  exp_t sbq[$];
  int   mh, mv, ma, mb;
  int   passed = 0, total = 0, cyc = 0;
  int   n_hs, n_vs, n_fs;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_raddr"}, raddr_a, 0);
    check({tag, "_rd_en"}, rd_a, 0);
    check({tag, "_pix"},   pix_a, 0);
    check({tag, "_de"},    de_a, 0);
    check({tag, "_hsync"}, hs_a, 1);
    check({tag, "_vsync"}, vs_a, 1);
    check({tag, "_fs"},    fs_a, 0);
  endtask

  task automatic model_reset();
    exp_t idle;
    idle = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix_a: '0, pix_b: '0};
    mh = 0; mv = 0; ma = 0; mb = 0;
    sbq.delete();
    sbq.push_back(idle);
    sbq.push_back(idle);
  endtask

  // Called right after a falling edge: checks the current cycle and advances the model.
  task automatic step();
    exp_t e, o;
    logic act, rd, pat;
    #1;
    pat = 1'b0;
`ifdef VGA_SCAN_PATTERN_EN
    pat = pat_en;
`endif
    act = scan_en && (mh < 4) && (mv < 3);
    rd  = act && !pat;
    check("rd_en_a", rd_a, rd);
    check("raddr_a", raddr_a, ma);
    check("rd_en_b", rd_b, rd);
    check("raddr_b", raddr_b, mb);
    e.de = act;
    e.hs = !((mh >= 5) && (mh < 7));
    e.vs = !(mv == 4);
    e.fs = scan_en && (mh == 0) && (mv == 0);
    if (!act) begin
      e.pix_a = '0; e.pix_b = '0;
    end else if (pat) begin
      e.pix_a = ((((mh >> 4) ^ (mv >> 4)) & 1) != 0) ? 8'hFF : 8'h00;
      e.pix_b = e.pix_a;
    end else begin
      e.pix_a = fb[ma]; e.pix_b = fb[mb];
    end
    sbq.push_back(e);
    if (sbq.size() > 2) begin
      o = sbq.pop_front();
      check("pix_de_a", de_a, o.de);
      check("hsync_a",  hs_a, o.hs);
      check("vsync_a",  vs_a, o.vs);
      check("fs_a",     fs_a, o.fs);
      check("pix_a",    pix_a, o.pix_a);
      check("pix_de_b", de_b, o.de);
      check("fs_b",     fs_b, o.fs);
      check("pix_b",    pix_b, o.pix_b);
    end
    if (!hs_a) n_hs++;
    if (!vs_a) n_vs++;
    if (fs_a)  n_fs++;
    if (!scan_en || (mh == 7 && mv == 5)) begin
      mh = 0; mv = 0; ma = 0; mb = 0;
    end else begin
      if (rd) begin ma = (ma + 1) % 12; mb = (mb + 1) % 10; end
      if (mh == 7) begin mh = 0; mv++; end else mh++;
    end
  endtask

  task automatic tick();
    step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 200) begin tick(); n++; end
    check("reach_pos", (mh == h && mv == v), 1);
  endtask

  vec_t vt[15];

  initial begin
    vt = '{
      '{0, 1'b1, 0, 0},  '{1, 1'b1, 1, 1},  '{3, 1'b1, 3, 3},  '{4, 1'b0, 4, 4},
      '{7, 1'b0, 4, 4},  '{8, 1'b1, 4, 4},  '{11, 1'b1, 7, 7}, '{16, 1'b1, 8, 8},
      '{17, 1'b1, 9, 9}, '{18, 1'b1, 10, 0}, '{19, 1'b1, 11, 1}, '{20, 1'b0, 0, 2},
      '{47, 1'b0, 0, 2}, '{48, 1'b1, 0, 0}, '{49, 1'b1, 1, 1}
    };
    for (int i = 0; i < 12; i++) fb[i] = 8'(8'h11 * (i + 1));
    rst_n = 1'b1; scan_en = 1'b0;
`ifdef VGA_SCAN_PATTERN_EN
    pat_en = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1 check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) tick();

    // Streaming from a fresh start: table checks on the address sequence plus frame-level counts.
    scan_en = 1'b1;
    for (int k = 0; k < 56; k++) begin
      if (k == 4) begin n_hs = 0; n_vs = 0; n_fs = 0; end
      step();
      foreach (vt[i]) begin
        if (vt[i].k == k) begin
          check("tbl_rd_en", rd_a, vt[i].rd);
          check("tbl_addr12", raddr_a, vt[i].a12);
          check("tbl_addr10", raddr_b, vt[i].a10);
        end
      end
      if (k == 51) begin
        check("frame_hsync_low", n_hs, 12);
        check("frame_vsync_low", n_vs, 8);
        check("frame_fs_pulses", n_fs, 1);
      end
      @(negedge clk);
      cyc++;
    end

    // Abort at h=2 of line 1, then resume.
    run_to(2, 1);
    scan_en = 1'b0;
    step();
    check("abort_rd_en", rd_a, 0);
    @(negedge clk); cyc++;
    tick();
    step();
    check("abort_de_flushed", de_a, 0);
    @(negedge clk); cyc++;
    for (int i = 0; i < 3; i++) tick();
    scan_en = 1'b1;
    step();
    check("resume_raddr", raddr_a, 0);
    check("resume_rd_en", rd_a, 1);
    @(negedge clk); cyc++;
    tick();
    step();
    check("resume_fs", fs_a, 1);
    @(negedge clk); cyc++;

    // Asynchronous reset in the middle of line 1.
    run_to(3, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check("rst_restart_rd", rd_a, 1);
    check("rst_restart_addr", raddr_a, 0);
    @(negedge clk); cyc++;
    for (int i = 0; i < 60; i++) tick();

`ifdef VGA_SCAN_PATTERN_EN
    pat_en = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    pat_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
`endif

    scan_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
